// File: rtl/board_pkg.sv
// Board-level constants shared by the switch front-end blocks.
package board_pkg;

   localparam int unsigned CLK_HZ         = 25000000;
   localparam int unsigned NUM_SWITCHES   = 4;
   localparam int unsigned DEBOUNCE_MS    = 10;
   localparam int unsigned DEBOUNCE_LIMIT = CLK_HZ / 1000 * DEBOUNCE_MS;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchroniser, stability counter and registered
// debounced level with single-cycle press/release pulses.
module debounce_channel #(
   parameter int unsigned DEBOUNCE_LIMIT = board_pkg::DEBOUNCE_LIMIT
) (
   input  logic iClk,
   input  logic iRst,
   input  logic iRaw,
   output logic oLevel,
   output logic oPress,
   output logic oRelease
);

   localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_LIMIT);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_LIMIT - 1);

   generate
      if (DEBOUNCE_LIMIT < 2) begin : gBadLimit
         $error("debounce_channel: DEBOUNCE_LIMIT must be at least 2");
      end
   endgenerate

   logic                 sync1;
   logic                 sync2;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cntNext;
   logic                 levelNext;
   logic                 pressNext;
   logic                 releaseNext;

   // A single agreeing cycle clears the count, so only an unbroken run commits.
   always_comb begin
      cntNext     = cnt;
      levelNext   = oLevel;
      pressNext   = 1'b0;
      releaseNext = 1'b0;
      if (sync2 == oLevel) begin
         cntNext = '0;
      end else if (cnt == CNT_LAST) begin
         cntNext     = '0;
         levelNext   = sync2;
         pressNext   = sync2;
         releaseNext = ~sync2;
      end else begin
         cntNext = cnt + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         cnt      <= '0;
         oLevel   <= 1'b0;
         oPress   <= 1'b0;
         oRelease <= 1'b0;
      end else begin
         sync1    <= iRaw;
         sync2    <= sync1;
         cnt      <= cntNext;
         oLevel   <= levelNext;
         oPress   <= pressNext;
         oRelease <= releaseNext;
      end
   end

endmodule

// File: rtl/switch_debounce_4.sv
// Four independent switch synchroniser/debouncer channels feeding the
// switch-to-LED block; pure instantiation and port mapping.
module switch_debounce_4
   import board_pkg::*;
#(
   parameter int unsigned DEBOUNCE_LIMIT = board_pkg::DEBOUNCE_LIMIT
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iSwitch_1,
   input  logic       iSwitch_2,
   input  logic       iSwitch_3,
   input  logic       iSwitch_4,
   output logic       oSwitch_1,
   output logic       oSwitch_2,
   output logic       oSwitch_3,
   output logic       oSwitch_4,
   output logic [3:0] oPress,
   output logic [3:0] oRelease
);

   logic [NUM_SWITCHES-1:0] rawVec;
   logic [NUM_SWITCHES-1:0] levelVec;

   assign rawVec    = {iSwitch_4, iSwitch_3, iSwitch_2, iSwitch_1};
   assign oSwitch_1 = levelVec[0];
   assign oSwitch_2 = levelVec[1];
   assign oSwitch_3 = levelVec[2];
   assign oSwitch_4 = levelVec[3];

   for (genvar i = 0; i < NUM_SWITCHES; i++) begin : gChan
      debounce_channel #(
         .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
      ) uChan (
         .iClk    (iClk),
         .iRst    (iRst),
         .iRaw    (rawVec[i]),
         .oLevel  (levelVec[i]),
         .oPress  (oPress[i]),
         .oRelease(oRelease[i])
      );
   end

endmodule

// File: tb/tb_switch_debounce_4.sv
// Directed + randomized bench for switch_debounce_4 against a windowed
// reference model of the debounce rule.
module tb_switch_debounce_4;

   localparam int unsigned LIM = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] sw  = 4'h0;
   logic       oSw1, oSw2, oSw3, oSw4;
   logic [3:0] oPress, oRelease;
   logic [3:0] oSw;

   int checkCnt = 0;
   int passCnt  = 0;

   // Model state: raw samples since reset, and the synchronised value seen each edge.
   logic [3:0] hist[$];
   logic [3:0] seqS[$];
   logic [3:0] mLevel   = 4'h0;
   logic [3:0] mPress   = 4'h0;
   logic [3:0] mRelease = 4'h0;

   always #5 clk = ~clk;

   assign oSw = {oSw4, oSw3, oSw2, oSw1};

   switch_debounce_4 #(.DEBOUNCE_LIMIT(LIM)) dut (
      .iClk     (clk),
      .iRst     (rst),
      .iSwitch_1(sw[0]),
      .iSwitch_2(sw[1]),
      .iSwitch_3(sw[2]),
      .iSwitch_4(sw[3]),
      .oSwitch_1(oSw1),
      .oSwitch_2(oSw2),
      .oSwitch_3(oSw3),
      .oSwitch_4(oSw4),
      .oPress   (oPress),
      .oRelease (oRelease)
   );

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checkCnt++;
      assert (obs === exp) passCnt++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   // A level commits when the synchronised input disagreed with it on each of the last LIM edges.
   task automatic modelEdge(input logic r, input logic [3:0] raw);
      logic [3:0] s;
      bit         allDiff;
      if (r) begin
         hist.delete();
         hist.push_back(4'h0);
         hist.push_back(4'h0);
         seqS.delete();
         mLevel   = 4'h0;
         mPress   = 4'h0;
         mRelease = 4'h0;
      end else begin
         s = hist[hist.size()-2];
         seqS.push_back(s);
         if (seqS.size() > LIM) void'(seqS.pop_front());
         mPress   = 4'h0;
         mRelease = 4'h0;
         for (int ch = 0; ch < 4; ch++) begin
            allDiff = (seqS.size() == LIM);
            foreach (seqS[j]) if (seqS[j][ch] == mLevel[ch]) allDiff = 1'b0;
            if (allDiff) begin
               mLevel[ch]   = s[ch];
               mPress[ch]   = s[ch];
               mRelease[ch] = ~s[ch];
            end
         end
         hist.push_back(raw);
         if (hist.size() > 2) void'(hist.pop_front());
      end
   endtask

   task automatic step(input logic [3:0] raw, input logic r);
      sw  = raw;
      rst = r;
      @(posedge clk);
      modelEdge(r, raw);
      #1;
      check("level", oSw, mLevel);
      check("press", oPress, mPress);
      check("release", oRelease, mRelease);
      check("exclusive", oPress & oRelease, 4'h0);
   endtask

   task automatic steps(input int n, input logic [3:0] raw);
      for (int i = 0; i < n; i++) step(raw, 1'b0);
   endtask

   initial begin
      logic [3:0] rsw;
      logic [7:0] bouncePat;

      // Reset with every switch high, then re-qualification with a press on all.
      for (int i = 0; i < 3; i++) step(4'hF, 1'b1);
      check("rst_level", oSw, 4'h0);
      steps(5, 4'hF);
      check("rst_nopulse_early", oPress, 4'h0);
      step(4'hF, 1'b0);
      check("rst_press_all", oPress, 4'hF);
      check("rst_level_all", oSw, 4'hF);
      step(4'hF, 1'b0);
      check("rst_press_single", oPress, 4'h0);
      steps(8, 4'h0);
      check("all_released", oSw, 4'h0);

      // Clean press on channel 2.
      steps(5, 4'b0010);
      check("press2_early", oSw, 4'h0);
      step(4'b0010, 1'b0);
      check("press2_pulse", oPress, 4'b0010);
      check("press2_level", oSw, 4'b0010);
      steps(3, 4'b0010);
      steps(8, 4'h0);

      // Bounce pattern on channel 1 never commits.
      bouncePat = 8'b0111_0111;
      for (int i = 0; i < 8; i++) step({3'b000, bouncePat[i]}, 1'b0);
      steps(8, 4'h0);
      check("bounce_level", oSw, 4'h0);

      // Threshold: 3-cycle pulse rejected, 4-cycle pulse accepted then released.
      steps(3, 4'b0100);
      steps(8, 4'h0);
      check("thresh3_level", oSw, 4'h0);
      steps(4, 4'b0100);
      steps(2, 4'h0);
      check("thresh4_level", oSw, 4'b0100);
      steps(3, 4'h0);
      step(4'h0, 1'b0);
      check("thresh4_release", oRelease, 4'b0100);
      check("thresh4_fall", oSw, 4'h0);
      steps(4, 4'h0);

      // Simultaneous press on channels 1 and 4.
      steps(5, 4'b1001);
      step(4'b1001, 1'b0);
      check("simul_press", oPress, 4'b1001);
      steps(8, 4'h0);

      // Mid-count reset on channel 2.
      step(4'b0010, 1'b0);
      step(4'b0010, 1'b0);
      step(4'b0010, 1'b1);
      check("midrst_nopulse", oPress, 4'h0);
      steps(5, 4'b0010);
      check("midrst_early", oSw, 4'h0);
      step(4'b0010, 1'b0);
      check("midrst_press", oPress, 4'b0010);
      steps(8, 4'h0);

      // Randomized bouncing with occasional resets.
      rsw = 4'h0;
      for (int i = 0; i < 1500; i++) begin
         for (int ch = 0; ch < 4; ch++)
            if ($urandom_range(0, 5) == 0) rsw[ch] = ~rsw[ch];
         step(rsw, ($urandom_range(0, 149) == 0));
      end

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
